// File: rtl/alu_pkg.sv
// Shared width default and opcode encodings for the pipelined ALU.
package alu_pkg;

   localparam int unsigned WIDTH = 8;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   typedef enum logic [2:0] {
      ALU_ADD = OP_ADD,
      ALU_SUB = OP_SUB,
      ALU_AND = OP_AND,
      ALU_OR  = OP_OR,
      ALU_XOR = OP_XOR,
      ALU_NOT = OP_NOT,
      ALU_SHL = OP_SHL,
      ALU_SHR = OP_SHR
   } alu_op_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU function; arithmetic wraps modulo 2^WIDTH, no flags.
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result
);

   always_comb begin
      o_result = '0;
      case (i_op)
         OP_ADD:  o_result = i_a + i_b;
         OP_SUB:  o_result = i_a - i_b;
         OP_AND:  o_result = i_a & i_b;
         OP_OR:   o_result = i_a | i_b;
         OP_XOR:  o_result = i_a ^ i_b;
         OP_NOT:  o_result = ~i_a;
         // shift distance is fixed at one; B plays no part
         OP_SHL:  o_result = {i_a[WIDTH-2:0], 1'b0};
         OP_SHR:  o_result = {1'b0, i_a[WIDTH-1:1]};
         default: o_result = '0;
      endcase
   end

endmodule

// File: rtl/alu_with_pipelining.sv
// Two-stage ALU: operands/opcode registered, then the computed result registered.
module alu_with_pipelining
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = alu_pkg::WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       op_code,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result
);

   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] w_result;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op <= '0;
         r_a  <= '0;
         r_b  <= '0;
      end else begin
         r_op <= op_code;
         r_a  <= A;
         r_b  <= B;
      end
   end

   alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .i_op     (r_op),
      .i_a      (r_a),
      .i_b      (r_b),
      .o_result (w_result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         result <= '0;
      end else begin
         result <= w_result;
      end
   end

endmodule

// File: tb/tb_alu_with_pipelining.sv
// Self-checking bench: directed vectors plus a random stream against a queue-style reference.
module tb_alu_with_pipelining;

   logic       clk;
   logic       reset;
   logic [2:0] op_code;
   logic [7:0] A;
   logic [7:0] B;
   logic [7:0] result;

   int errors;
   int checks;

   // reference pipeline: value sampled last edge, and value due on result now
   int pend_val;
   int exp_val;
   int pend_want;
   int exp_want;

   alu_with_pipelining #(
      .WIDTH (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .op_code (op_code),
      .A       (A),
      .B       (B),
      .result  (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int ref_f(input int op, input int a, input int b);
      case (op)
         0: return (a + b) % 256;
         1: return (a - b + 256) % 256;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return 255 - a;
         6: return (a * 2) % 256;
         7: return a / 2;
         default: return 0;
      endcase
   endfunction

   // Apply one cycle of inputs; want >= 0 is a hand-derived value expected two edges later.
   task automatic step(input string tag, input bit rst, input int op, input int a, input int b,
                       input int want);
      reset   = rst;
      op_code = op[2:0];
      A       = a[7:0];
      B       = b[7:0];
      @(posedge clk);
      if (rst) begin
         exp_val   = 0;
         pend_val  = 0;
         exp_want  = -1;
         pend_want = -1;
      end else begin
         exp_val   = pend_val;
         pend_val  = ref_f(op, a, b);
         exp_want  = pend_want;
         pend_want = want;
      end
      #1;
      checks++;
      assert (result === exp_val[7:0])
      else begin
         errors++;
         $error("FAIL %s: result=%0d expected=%0d", tag, result, exp_val);
      end
      if (exp_want >= 0) begin
         checks++;
         assert (result === exp_want[7:0])
         else begin
            errors++;
            $error("FAIL %s_const: result=%0d expected=%0d", tag, result, exp_want);
         end
      end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      pend_val  = 0;
      exp_val   = 0;
      pend_want = -1;
      exp_want  = -1;
      reset     = 1'b1;
      op_code   = '0;
      A         = '0;
      B         = '0;

      // reset held several edges with zero inputs
      step("rst0", 1, 0, 0, 0, -1);
      step("rst1", 1, 0, 0, 0, -1);
      step("rst2", 1, 0, 0, 0, -1);

      // directed stream, one op per cycle
      step("add",  0, 0, 25,   17,   42);
      step("sub",  0, 1, 50,   10,   40);
      step("and",  0, 2, 8'hAA, 8'hCC, 136);
      step("or",   0, 3, 8'h33, 8'hC3, 243);
      step("xor",  0, 4, 8'hF0, 8'h0F, 255);
      step("not",  0, 5, 8'hAA, 0,    85);
      step("shl",  0, 6, 10,   0,    20);
      step("shr",  0, 7, 16,   0,    8);
      // wrap and edge values
      step("addw", 0, 0, 200,  100,  44);
      step("subw", 0, 1, 10,   50,   216);
      step("shlm", 0, 6, 8'h81, 0,   2);
      step("shr1", 0, 7, 1,    0,    0);
      step("not0", 0, 5, 0,    0,    255);
      // B must be ignored by NOT / shifts
      step("notb", 0, 5, 8'hAA, 8'hFF, 85);
      step("shlb", 0, 6, 10,   8'hFF, 20);
      step("shrb", 0, 7, 16,   8'hFF, 8);
      // latency: constant ADD 1+1, a single SUB 9-4, then ADD again
      step("lat0", 0, 0, 1, 1, 2);
      step("lat1", 0, 0, 1, 1, 2);
      step("lat2", 0, 0, 1, 1, 2);
      step("lat3", 0, 1, 9, 4, 5);
      step("lat4", 0, 0, 1, 1, 2);
      step("lat5", 0, 0, 1, 1, 2);
      step("lat6", 0, 0, 1, 1, 2);
      // reset with ops in flight: both discarded
      step("fl0",  0, 0, 100, 23, -1);
      step("fl1",  0, 4, 8'h5A, 8'h0F, -1);
      step("flr",  1, 0, 77, 77, -1);
      step("fla",  0, 0, 3, 4, 7);
      step("flb",  0, 0, 0, 0, 0);
      step("flc",  0, 0, 0, 0, -1);

      // random stream with occasional reset pulses
      for (int i = 0; i < 1000; i++) begin
         step("rand", ($urandom_range(0, 49) == 0), $urandom_range(0, 7),
              $urandom_range(0, 255), $urandom_range(0, 255), -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
